// File: rtl/aes_iter_core_if.sv
// Plaintext-in / ciphertext-out stream bundle for aes_iter_core.
// Both directions: a beat moves on a rising clk edge where valid and ready are both 1; valid must not depend on ready.
interface aes_iter_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor: one round per clock, round keys loaded externally.
// Optional macro AES_ZEROIZE_EN adds a zeroize input that aborts work and wipes the key store.
module aes_iter_core #(
   parameter  int KEY_BITS = 128,
   localparam int NR       = KEY_BITS / 32 + 6,
   localparam int RK_AW    = $clog2(NR + 1)
) (
   input  logic             clk,
   input  logic             kill_n,
   input  logic             key_wr_en,
   input  logic [RK_AW-1:0] key_wr_addr,
   input  logic [127:0]     key_wr_data,
   output logic             key_ready,
`ifdef AES_ZEROIZE_EN
   input  logic             zeroize,
`endif
   aes_iter_core_if.slave   strm,
   output logic             busy,
   output logic             key_err_irq_pulse,
   output logic [1:0]       dbg_state
);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
   end

   localparam logic [RK_AW-1:0] NR_A = RK_AW'(NR);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef AES_ZEROIZE_EN
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_HOLD, S_ZERO} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_HOLD} state_t;
`endif

   state_t           state_q, state_d;
   logic [RK_AW-1:0] rnd_q;
   logic [127:0]     st_q, out_q, ss;
   logic [NR:0]      mask_q;
   logic             key_ready_q, err_q, in_ready_c, accept, key_acc, zap;
   logic [127:0]     rk [0:NR];

   function automatic logic [7:0] sbox(input logic [7:0] x);
      int idx;
      idx = 2047 - 8 * int'(x);
      return SBOX[idx -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte k sits at [127-8k -: 8]; column c holds bytes 4c..4c+3 (rows 0..3).
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

`ifdef AES_ZEROIZE_EN
   logic [RK_AW-1:0] zcnt_q;
   assign zap = zeroize;
`else
   assign zap = 1'b0;
`endif

   assign ss      = sub_shift(st_q);
   assign key_acc = key_wr_en && (key_wr_addr <= NR_A) && !zap &&
                    (state_q == S_IDLE || state_q == S_HOLD);
   assign accept  = strm.in_valid && in_ready_c;

   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      busy       = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready_c = key_ready_q;
            if (strm.in_valid && key_ready_q) state_d = S_ROUND;
         end
         S_ROUND: begin
            busy = 1'b1;
            if (rnd_q == NR_A) state_d = S_HOLD;
         end
         S_HOLD: begin
            in_ready_c = key_ready_q && strm.out_ready;
            if (strm.out_ready) state_d = (strm.in_valid && key_ready_q) ? S_ROUND : S_IDLE;
         end
`ifdef AES_ZEROIZE_EN
         S_ZERO: begin
            busy = 1'b1;
            if (zcnt_q == NR_A) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
`ifdef AES_ZEROIZE_EN
      if (zap) begin
         state_d    = S_ZERO;
         in_ready_c = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         st_q        <= '0;
         out_q       <= '0;
         mask_q      <= '0;
         key_ready_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef AES_ZEROIZE_EN
         zcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         key_ready_q <= &mask_q;
         err_q       <= key_wr_en && !key_acc;
         if (key_acc) mask_q[key_wr_addr] <= 1'b1;
         if (accept) begin
            st_q  <= strm.in_data ^ rk[0];
            rnd_q <= RK_AW'(1);
         end else if (state_q == S_ROUND) begin
            if (rnd_q == NR_A) begin
               out_q <= ss ^ rk[NR];
            end else begin
               st_q  <= mix_cols(ss) ^ rk[rnd_q];
               rnd_q <= rnd_q + RK_AW'(1);
            end
         end
`ifdef AES_ZEROIZE_EN
         if (state_q == S_ZERO) zcnt_q <= zcnt_q + RK_AW'(1);
         // Zeroize wins over everything above, including a key write in the same cycle.
         if (zap) begin
            mask_q      <= '0;
            key_ready_q <= 1'b0;
            out_q       <= '0;
            rnd_q       <= '0;
            zcnt_q      <= '0;
         end
`endif
      end
   end

   // Key RAM contents survive kill_n; only the valid mask is cleared.
   always_ff @(posedge clk) begin
`ifdef AES_ZEROIZE_EN
      if (state_q == S_ZERO) rk[zcnt_q] <= '0;
`endif
      if (key_acc) rk[key_wr_addr] <= key_wr_data;
   end

   assign strm.in_ready     = in_ready_c;
   assign strm.out_valid    = (state_q == S_HOLD);
   assign strm.out_data     = out_q;
   assign key_ready         = key_ready_q;
   assign key_err_irq_pulse = err_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS-197 vectors plus random blocks checked against a byte-level AES model.
// Define AES_ZEROIZE_EN for both files to exercise the zeroize path.
module tb_aes_iter_core;
   parameter int KEY_BITS = 128;
   localparam int NR = KEY_BITS / 32 + 6;
   localparam int NK = KEY_BITS / 32;
   localparam int AW = $clog2(NR + 1);

   logic          clk = 1'b0;
   logic          kill_n = 1'b1;
   logic          key_wr_en = 1'b0;
   logic [AW-1:0] key_wr_addr = '0;
   logic [127:0]  key_wr_data = '0;
   logic          key_ready, busy, key_err_irq_pulse;
   logic [1:0]    dbg_state;
`ifdef AES_ZEROIZE_EN
   logic          zeroize = 1'b0;
`endif

   aes_iter_core_if ifc ();

   aes_iter_core #(.KEY_BITS(KEY_BITS)) dut (
      .clk               (clk),
      .kill_n            (kill_n),
      .key_wr_en         (key_wr_en),
      .key_wr_addr       (key_wr_addr),
      .key_wr_data       (key_wr_data),
      .key_ready         (key_ready),
`ifdef AES_ZEROIZE_EN
      .zeroize           (zeroize),
`endif
      .strm              (ifc),
      .busy              (busy),
      .key_err_irq_pulse (key_err_irq_pulse),
      .dbg_state         (dbg_state)
   );

   always #5 clk = ~clk;

   int           n_assert = 0;
   int           n_fail = 0;
   logic [7:0]   sb [256];
   logic [127:0] mrk [NR+1];
   logic [127:0] grk [NR+1];
   logic [127:0] gold_pt, gold_ct, pt_b;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] v, input int k);
      return 8'((v << k) | (v >> (8 - k)));
   endfunction

   // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < NK; i++) w[i] = key[255-32*i -: 32];
      for (int i = NK; i < 4 * (NR + 1); i++) begin
         tmp = w[i-1];
         if (i % NK == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gm(rc, 8'h02);
         end else if (NK > 6 && i % NK == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-NK] ^ tmp;
      end
      for (int j = 0; j <= NR; j++) grk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ mrk[0][127-8*k -: 8];
      for (int rd = 1; rd <= NR; rd++) begin
         for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
         if (rd < NR) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ mrk[rd][127-8*k -: 8];
      end
      r = '0;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_key(input int a, input logic [127:0] d);
      key_wr_en   = 1'b1;
      key_wr_addr = AW'(a);
      key_wr_data = d;
      cyc();
      key_wr_en   = 1'b0;
   endtask

   task automatic load_gold_keys();
      for (int a = 0; a <= NR; a++) begin
         wr_key(a, grk[a]);
         mrk[a] = grk[a];
      end
   endtask

   // Returns just after the accepting edge.
   task automatic send(input logic [127:0] d);
      int n;
      n = 0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      #1;
      while (!ifc.in_ready && n < 50) begin cyc(); n++; end
      check("send_timeout", 128'(n >= 50), 128'(0));
      cyc();
      ifc.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n, nb;
      n = 0; nb = 0;
      while (!ifc.out_valid && n < 100) begin
         if (busy) nb++;
         cyc();
         n++;
      end
      check({tag, "_latency"}, 128'(n), 128'(NR));
      check({tag, "_busy_cycles"}, 128'(nb), 128'(NR));
   endtask

   task automatic run_block(input logic [127:0] pt, input int hold, input logic [127:0] exp, input string tag);
      ifc.out_ready = 1'b0;
      send(pt);
      wait_out(tag);
      for (int h = 0; h < hold; h++) begin
         check({tag, "_hold_valid"}, 128'(ifc.out_valid), 128'(1));
         check({tag, "_hold_data"}, ifc.out_data, exp);
         cyc();
      end
      ifc.out_ready = 1'b1;
      check({tag, "_data"}, ifc.out_data, exp);
      cyc();
      ifc.out_ready = 1'b0;
      check({tag, "_valid_drop"}, 128'(ifc.out_valid), 128'(0));
   endtask

   initial begin
      int n, bad, a;
      logic [127:0] d, p;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b0;
      build_sbox();
      expand({8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f,
              (KEY_BITS >= 192) ? 64'h1011121314151617 : 64'h0,
              (KEY_BITS == 256) ? 64'h18191a1b1c1d1e1f : 64'h0});
      gold_pt = 128'h00112233445566778899aabbccddeeff;
      gold_ct = (KEY_BITS == 128) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                (KEY_BITS == 192) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                    128'h8ea2b7ca516745bfeafc49904b496089;

      // Reset values
      #1 kill_n = 1'b0;
      #1;
      check("rst_key_ready", 128'(key_ready), 128'(0));
      check("rst_in_ready", 128'(ifc.in_ready), 128'(0));
      check("rst_out_valid", 128'(ifc.out_valid), 128'(0));
      check("rst_out_data", ifc.out_data, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_irq", 128'(key_err_irq_pulse), 128'(0));
      cyc(); cyc();
      kill_n = 1'b1;
      cyc();

      // Keys 0..NR-1 only: core must hold off input
      for (int k = 0; k < NR; k++) begin wr_key(k, grk[k]); mrk[k] = grk[k]; end
      ifc.in_valid = 1'b1;
      ifc.in_data  = gold_pt;
      repeat (3) cyc();
      check("partial_in_ready", 128'(ifc.in_ready), 128'(0));
      check("partial_key_ready", 128'(key_ready), 128'(0));
      ifc.in_valid = 1'b0;

      // Out-of-range key address
      wr_key(NR + 1, rand128());
      check("bad_addr_irq", 128'(key_err_irq_pulse), 128'(1));
      cyc();
      check("bad_addr_irq_clear", 128'(key_err_irq_pulse), 128'(0));
      check("bad_addr_key_ready", 128'(key_ready), 128'(0));

      // Last key: key_ready lags the mask by one cycle
      wr_key(NR, grk[NR]);
      mrk[NR] = grk[NR];
      check("key_ready_lag", 128'(key_ready), 128'(0));
      cyc();
      check("key_ready_set", 128'(key_ready), 128'(1));

      run_block(gold_pt, 0, gold_ct, "golden");

      // Backpressure, then back-to-back handoff
      pt_b = rand128();
      send(gold_pt);
      wait_out("bp");
      ifc.in_valid = 1'b1;
      ifc.in_data  = pt_b;
      for (int h = 0; h < 5; h++) begin
         check("bp_data_stable", ifc.out_data, gold_ct);
         check("bp_in_ready_low", 128'(ifc.in_ready), 128'(0));
         cyc();
      end
      ifc.out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 128'(ifc.in_ready), 128'(1));
      check("b2b_out_valid", 128'(ifc.out_valid), 128'(1));
      cyc();
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      check("b2b_valid_drop", 128'(ifc.out_valid), 128'(0));
      check("b2b_busy", 128'(busy), 128'(1));
      wait_out("b2b");
      check("b2b_data", ifc.out_data, model_enc(pt_b));
      ifc.out_ready = 1'b1;
      cyc();
      ifc.out_ready = 1'b0;

      // Key write during ROUND is rejected and does not disturb the block
      send(gold_pt);
      wr_key(3, rand128());
      check("round_wr_irq", 128'(key_err_irq_pulse), 128'(1));
      n = 0;
      while (!ifc.out_valid && n < 100) begin cyc(); n++; end
      check("round_wr_timeout", 128'(n >= 100), 128'(0));
      check("round_wr_data", ifc.out_data, gold_ct);
      check("round_wr_irq_clear", 128'(key_err_irq_pulse), 128'(0));
      ifc.out_ready = 1'b1;
      cyc();
      ifc.out_ready = 1'b0;

      // Random blocks, random key rewrites and random backpressure
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            a = $urandom_range(0, NR);
            d = rand128();
            wr_key(a, d);
            mrk[a] = d;
         end
         p = rand128();
         run_block(p, $urandom_range(0, 3), model_enc(p), "rand");
      end

      // Asynchronous kill mid-round (round 5)
      send(rand128());
      repeat (4) cyc();
      #3 kill_n = 1'b0;
      #1;
      check("kill_out_valid", 128'(ifc.out_valid), 128'(0));
      check("kill_out_data", ifc.out_data, 128'(0));
      check("kill_busy", 128'(busy), 128'(0));
      check("kill_key_ready", 128'(key_ready), 128'(0));
      check("kill_in_ready", 128'(ifc.in_ready), 128'(0));
      cyc();
      kill_n = 1'b1;
      cyc();
      check("kill_key_ready_after", 128'(key_ready), 128'(0));
      load_gold_keys();
      cyc();
      run_block(gold_pt, 1, gold_ct, "post_kill");

`ifdef AES_ZEROIZE_EN
      // Zeroize at round 3
      send(gold_pt);
      cyc(); cyc();
      zeroize = 1'b1;
      cyc();
      zeroize = 1'b0;
      check("zero_out_data", ifc.out_data, 128'(0));
      check("zero_key_ready", 128'(key_ready), 128'(0));
      ifc.in_valid = 1'b1;
      ifc.in_data  = gold_pt;
      bad = 0;
      for (int k = 0; k < NR + 1; k++) begin
         if (ifc.out_valid || ifc.in_ready || !busy) bad++;
         if (k == 0) begin
            key_wr_en   = 1'b1;
            key_wr_addr = '0;
            key_wr_data = rand128();
         end
         if (k == 1) begin
            key_wr_en = 1'b0;
            check("zero_wr_irq", 128'(key_err_irq_pulse), 128'(1));
         end
         cyc();
      end
      ifc.in_valid = 1'b0;
      check("zero_window", 128'(bad), 128'(0));
      check("zero_done_busy", 128'(busy), 128'(0));
      load_gold_keys();
      cyc();
      run_block(gold_pt, 0, gold_ct, "post_zero");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
